// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected accelerator: default
// datapath widths and the scan controller state encoding.
package fc_pkg;

    localparam int FC_DATA_WIDTH  = 24;
    localparam int FC_ADDR_WIDTH  = 10;
    localparam int FC_NUM_CLASSES = 10;
    localparam int FC_IDX_WIDTH   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/argmax_scan_if.sv
// Handshake and acc_mem read-port bundle of the argmax scanner.
interface argmax_scan_if import fc_pkg::*; #(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ADDR_WIDTH = FC_ADDR_WIDTH,
    parameter int IDX_WIDTH  = FC_IDX_WIDTH
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  result_valid;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [IDX_WIDTH-1:0]  max_index;
    logic [DATA_WIDTH-1:0] max_value;

    // Scanner side
    modport slave (
        input  start, mem_rdata,
        output busy, done, result_valid, mem_en, mem_addr, max_index, max_value
    );

    // Requester / memory side
    modport master (
        output start, mem_rdata,
        input  busy, done, result_valid, mem_en, mem_addr, max_index, max_value
    );
endinterface

// File: rtl/rd_tag_pipe.sv
// Delay line that travels alongside an acc_mem read so each returning
// word arrives together with its valid flag and class index.
module rd_tag_pipe #(
    parameter int DEPTH     = 1,
    parameter int IDX_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [IDX_WIDTH-1:0] i_idx,
    output logic                 o_valid,
    output logic [IDX_WIDTH-1:0] o_idx
);
    logic                 r_valid [DEPTH];
    logic [IDX_WIDTH-1:0] r_idx   [DEPTH];

    // Shift the {valid, index} tag one stage per cycle; reset drops in-flight tags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_idx[i]   <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];
endmodule

// File: rtl/argmax_scan.sv
// Classifier output stage: streams NUM_CLASSES accumulators from acc_mem
// and reports the index/value of the largest signed one.
//
// state | meaning
// IDLE  | waiting for start, result outputs held
// ISSUE | one read per cycle, addresses BASE_ADDR..BASE_ADDR+NUM_CLASSES-1
// DRAIN | reads stopped, waiting for the last tagged word to return
// DONE  | one-cycle done pulse, result_valid raised
module argmax_scan import fc_pkg::*; #(
    parameter int DATA_WIDTH  = FC_DATA_WIDTH,
    parameter int NUM_CLASSES = FC_NUM_CLASSES,
    parameter int ADDR_WIDTH  = FC_ADDR_WIDTH,
    parameter int BASE_ADDR   = 0,
    parameter int RD_LATENCY  = 1,
    parameter int IDX_WIDTH   = FC_IDX_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    argmax_scan_if.slave  bus
);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    scan_state_t           r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_result_valid;
    logic                  r_mem_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [IDX_WIDTH-1:0]  r_issue_idx;
    logic [IDX_WIDTH-1:0]  r_max_index;
    logic [DATA_WIDTH-1:0] r_max_value;

    logic                  w_tag_valid;
    logic [IDX_WIDTH-1:0]  w_tag_idx;
    logic                  w_last_return;

    // The tag enters together with the registered read request, so after
    // RD_LATENCY stages it lines up with the returning data word.
    rd_tag_pipe #(
        .DEPTH     (RD_LATENCY),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_mem_en),
        .i_idx   (r_issue_idx),
        .o_valid (w_tag_valid),
        .o_idx   (w_tag_idx)
    );

    assign w_last_return = w_tag_valid && (w_tag_idx == LAST_IDX);

    // Scan sequencing: read issue, drain, done pulse and handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            r_mem_en       <= 1'b0;
            r_mem_addr     <= '0;
            r_issue_idx    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state        <= ST_ISSUE;
                        r_busy         <= 1'b1;
                        r_result_valid <= 1'b0;
                        r_mem_en       <= 1'b1;
                        r_mem_addr     <= BASE;
                        r_issue_idx    <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (r_issue_idx == LAST_IDX) begin
                        r_mem_en <= 1'b0;
                        r_state  <= ST_DRAIN;
                    end else begin
                        r_issue_idx <= r_issue_idx + IDX_WIDTH'(1);
                        r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_last_return) begin
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Running maximum: class 0 seeds it, later classes win only if strictly larger
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_index <= '0;
            r_max_value <= '0;
        end else if (w_tag_valid) begin
            if ((w_tag_idx == '0) || ($signed(bus.mem_rdata) > $signed(r_max_value))) begin
                r_max_index <= w_tag_idx;
                r_max_value <= bus.mem_rdata;
            end
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.result_valid = r_result_valid;
    assign bus.mem_en       = r_mem_en;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.max_index    = r_max_index;
    assign bus.max_value    = r_max_value;
endmodule
